rewire_stream_host: RTL and testbench
=====================================

Name: rewire_stream_host

Overview:
- Host-side driver for a compiled ReWire lockstep device. The device has a byte input, a byte output and a continue flag, and advances one resumption step every clk.
- This block converts an upstream valid/ready byte stream into device steps. It captures the device output for every valid step into a small FIFO and presents it as a downstream valid/ready stream.
- It detects device termination (continue deasserted), and counts steps and dropped outputs.
- It sits between a bus/testbench stream source and the top-level of any generated ReWire device.

Parameters:
- DATA_W, 8, width of stream data and device in/out byte.
- FIFO_DEPTH, 4, output capture FIFO entries (power of two, >=2).
- IDLE_BYTE, 8'h00, value driven on dev_in during non-valid steps.
- CNT_W, 16, width of step_cnt and overflow_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- restart  in  1  single-cycle pulse; re-resets the device and clears counters.
- s_valid  in  1  upstream byte valid.
- s_data  in  DATA_W  upstream byte.
- s_ready  out  1  upstream ready.
- dev_rst  out  1  reset to the device (active-high).
- dev_in  out  DATA_W  device input.
- dev_out  in  DATA_W  device output (combinational from device state and dev_in).
- dev_continue  in  1  device continue flag for the current step.
- m_valid  out  1  downstream byte valid.
- m_data  out  DATA_W  downstream byte (FIFO head).
- m_ready  in  1  downstream ready.
- done  out  1  device has halted.
- step_cnt  out  CNT_W  number of valid steps taken.
- overflow_cnt  out  CNT_W  outputs dropped because the FIFO was full.

Behaviour:
- Reset values: s_ready=0, dev_rst=1, dev_in=IDLE_BYTE, m_valid=0, done=0, step_cnt=0, overflow_cnt=0, FIFO empty, state=DEV_RST.
- States:
  - DEV_RST: dev_rst=1 for exactly one cycle, then go to RUN.
  - RUN: s_ready=1, dev_rst=0.
  - HALTED: s_ready=0, done=1.
- Transitions: DEV_RST->RUN unconditionally. RUN->HALTED on a valid step with dev_continue=0. HALTED->DEV_RST on restart. restart in RUN also goes to DEV_RST; it takes priority over a same-cycle step and discards that step.
- Step definition: in RUN, the device steps every cycle regardless of s_valid.
  - Valid step (s_valid & s_ready): dev_in=s_data.
  - Otherwise: dev_in=IDLE_BYTE, dev_out is not captured, and dev_continue is ignored.
- dev_in is combinational from s_data/s_valid/state.
- Capture on a valid step: push dev_out into the FIFO and increment step_cnt.
  - If the FIFO is full and not popping this cycle: drop the byte and increment overflow_cnt.
  - Both counters saturate at all-ones.
- Halt: the final valid step's dev_out is captured, using the same full/drop rules. In HALTED, dev_in=IDLE_BYTE and dev_rst=0; the device keeps clocking but no output is captured.
- FIFO behaviour:
  - Latency: a byte pushed in cycle N is visible as m_valid/m_data in cycle N+1.
  - A pop occurs on m_valid & m_ready.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no drop.
  - Push and pop in the same cycle when empty: the push lands and m_valid rises next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH and use an extra wrap bit for the full/empty distinction.
- restart flushes the FIFO, clears step_cnt, overflow_cnt and done, and takes effect on the next edge.
- Async rst mid-operation: all state returns to reset values immediately; any in-flight byte is lost.
- m_data holds the FIFO head and is stable while m_valid & !m_ready.

Decomposition:
- Package rewire_host_pkg:
  - state enum {DEV_RST, RUN, HALTED}.
  - localparams for pointer width, clog2(FIFO_DEPTH).
  - Saturating-increment function.
- Sub-module rewire_host_fifo (synchronous FIFO, push/pop/full/empty/head; drop decision made in the parent).

Test Plan:
Bench device model: dev_out = dev_in ^ 8'hFF; dev_continue = 0 when dev_in == 8'hEE, else 1.
- Reset then stream 8'h01, 8'h02, 8'h03 back-to-back with m_ready=1 -> after a 1-cycle DEV_RST, m_data sequence is 8'hFE, 8'hFD, 8'hFC, each one cycle after its input; step_cnt=3.
- With m_ready=0, send 6 bytes 8'h10..8'h15 (FIFO_DEPTH=4) -> FIFO holds 8'hEF, 8'hEE, 8'hED, 8'hEC; overflow_cnt=2; draining yields exactly those 4 bytes.
- Send 8'h20, then 8'hEE, then 8'h21 -> outputs 8'hDF, 8'h11; done=1 and s_ready=0 from the cycle after 8'hEE; 8'h21 is not accepted; step_cnt=2.
- In HALTED, pulse restart -> one cycle dev_rst=1; counters=0, done=0, FIFO empty; then 8'h00 -> output 8'hFF.
- FIFO full with m_ready=1 and a simultaneous valid push -> no drop, overflow_cnt unchanged, order preserved.
- Assert rst mid-stream with 2 bytes queued -> m_valid=0, dev_rst=1, counters=0 within the same cycle.

Source files
------------

// File: rtl/rewire_host_pkg.sv
// Shared types and helpers for the ReWire stream host.
// Holds the host FSM states, default FIFO pointer geometry and a saturating counter step.
package rewire_host_pkg;

    typedef enum logic [1:0] {
        DEV_RST = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int PTR_W_DEF      = $clog2(FIFO_DEPTH_DEF);

    // Increment a counter of width w (1..32) held in the low bits of v; it sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_val) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rewire_host_fifo.sv
// Synchronous capture FIFO for device output bytes.
// Push-while-full is accepted only when a pop happens in the same cycle; the parent decides drops.
module rewire_host_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                do_push;
    logic                do_pop;

    // Pointers carry an extra wrap bit so equal indices can mean either empty or full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/rewire_stream_host.sv
// Host driver for a lockstep ReWire device: turns a valid/ready byte stream into device steps
// and buffers the device output for a downstream valid/ready consumer.
module rewire_stream_host
    import rewire_host_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [DATA_W-1:0] IDLE_BYTE  = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              dev_rst,
    output logic [DATA_W-1:0] dev_in,
    input  logic [DATA_W-1:0] dev_out,
    input  logic              dev_continue,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              done,
    output logic [CNT_W-1:0]  step_cnt,
    output logic [CNT_W-1:0]  overflow_cnt
);
    state_t state;
    state_t state_nxt;

    logic valid_step;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic fifo_push;
    logic drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DEV_RST;
        else     state <= state_nxt;
    end

    // restart outranks a same-cycle step; a step with continue low is the last one captured.
    always_comb begin
        state_nxt = state;
        case (state)
            DEV_RST: state_nxt = RUN;
            RUN: begin
                if (restart)                      state_nxt = DEV_RST;
                else if (s_valid && !dev_continue) state_nxt = HALTED;
            end
            HALTED: begin
                if (restart) state_nxt = DEV_RST;
            end
            default: state_nxt = DEV_RST;
        endcase
    end

    assign s_ready = (state == RUN);
    assign dev_rst = (state == DEV_RST);
    assign done    = (state == HALTED);
    assign dev_in  = (s_ready && s_valid) ? s_data : IDLE_BYTE;

    assign valid_step = s_valid && s_ready && !restart;
    assign fifo_pop   = m_valid && m_ready;
    assign drop       = valid_step && fifo_full && !fifo_pop;
    assign fifo_push  = valid_step && !drop;
    assign m_valid    = !fifo_empty;

    rewire_host_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (restart),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (dev_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (m_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt     <= '0;
            overflow_cnt <= '0;
        end else if (restart) begin
            step_cnt     <= '0;
            overflow_cnt <= '0;
        end else begin
            if (valid_step) step_cnt     <= CNT_W'(sat_inc(32'(step_cnt), CNT_W));
            if (drop)       overflow_cnt <= CNT_W'(sat_inc(32'(overflow_cnt), CNT_W));
        end
    end

endmodule

// File: tb/tb_rewire_stream_host.sv
// Scoreboard bench for rewire_stream_host with an XOR-0xFF device that halts on input 0xEE.
module tb_rewire_stream_host;
    localparam int DEPTH = 4;
    localparam int PH_DEVRST = 0, PH_RUN = 1, PH_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        dev_rst;
    logic [7:0]  dev_in;
    logic [7:0]  dev_out;
    logic        dev_continue;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        done;
    logic [15:0] step_cnt;
    logic [15:0] overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the host should hold, expressed as a phase, a byte queue and two tallies.
    int          m_phase = PH_DEVRST;
    logic [7:0]  exp_q[$];
    int          m_steps = 0;
    int          m_ovf   = 0;

    assign dev_out      = dev_in ^ 8'hFF;
    assign dev_continue = (dev_in != 8'hEE);

    always #5 clk = ~clk;

    rewire_stream_host dut (
        .clk(clk), .rst(rst), .restart(restart),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .dev_rst(dev_rst), .dev_in(dev_in), .dev_out(dev_out), .dev_continue(dev_continue),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .done(done), .step_cnt(step_cnt), .overflow_cnt(overflow_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the model between edges, then advances the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_s_ready", 32'(s_ready), 0);
            chk("rst_dev_rst", 32'(dev_rst), 1);
            chk("rst_m_valid", 32'(m_valid), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_step_cnt", 32'(step_cnt), 0);
            chk("rst_overflow_cnt", 32'(overflow_cnt), 0);
            chk("rst_dev_in", 32'(dev_in), 0);
            m_phase = PH_DEVRST;
            exp_q.delete();
            m_steps = 0;
            m_ovf   = 0;
        end else begin
            chk("s_ready", 32'(s_ready), 32'(m_phase == PH_RUN));
            chk("dev_rst", 32'(dev_rst), 32'(m_phase == PH_DEVRST));
            chk("done", 32'(done), 32'(m_phase == PH_HALT));
            chk("step_cnt", 32'(step_cnt), 32'(m_steps));
            chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
            chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
            chk("dev_in", 32'(dev_in), (m_phase == PH_RUN && s_valid) ? 32'(s_data) : 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (restart) begin
                exp_q.delete();
                m_steps = 0;
                m_ovf   = 0;
                m_phase = (m_phase == PH_DEVRST) ? PH_RUN : PH_DEVRST;
            end else if (m_phase == PH_DEVRST) begin
                m_phase = PH_RUN;
            end else if (m_phase == PH_RUN && s_valid) begin
                if (m_steps < 65535) m_steps++;
                if (exp_q.size() < DEPTH) exp_q.push_back(s_data ^ 8'hFF);
                else if (m_ovf < 65535) m_ovf++;
                if (s_data == 8'hEE) m_phase = PH_HALT;
            end
        end
    end

    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic mr, input logic rs);
        s_valid = v; s_data = d; m_ready = mr; restart = rs;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b1; s_data = b;
        for (int k = 0; k < 30 && !acc; k++) begin
            acc = s_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] ovf_before;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back stream, consumer always ready
        m_ready = 1'b1;
        send(8'h01); send(8'h02); send(8'h03);
        idle(2);
        chk("t1_step_cnt", 32'(step_cnt), 3);

        // consumer stalled: four captured, two dropped, then drain
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
        idle(1);
        chk("t2_overflow_cnt", 32'(overflow_cnt), 2);
        m_ready = 1'b1;
        idle(6);
        chk("t2_drained", 32'(m_valid), 0);

        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle(1);

        // halting byte
        send(8'h20); send(8'hEE);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'h21, 1'b1, 1'b0);
        idle(2);
        chk("t3_done", 32'(done), 1);
        chk("t3_s_ready", 32'(s_ready), 0);
        chk("t3_step_cnt", 32'(step_cnt), 2);

        // restart from HALTED
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t4_dev_rst", 32'(dev_rst), 1);
        chk("t4_step_cnt", 32'(step_cnt), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_m_valid", 32'(m_valid), 0);
        send(8'h00);
        idle(3);

        // full FIFO with simultaneous pop and push
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
        ovf_before = overflow_cnt;
        m_ready = 1'b1;
        send(8'h34);
        idle(8);
        chk("t5_overflow_unchanged", 32'(overflow_cnt), 32'(ovf_before));

        // async reset with bytes queued
        m_ready = 1'b0;
        send(8'h40); send(8'h41);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_m_valid", 32'(m_valid), 0);
        chk("t6_dev_rst", 32'(dev_rst), 1);
        chk("t6_step_cnt", 32'(step_cnt), 0);
        chk("t6_overflow_cnt", 32'(overflow_cnt), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            logic       rs;
            d  = ($urandom_range(0, 15) == 0) ? 8'hEE : 8'($urandom);
            rs = done ? 1'b1 : ($urandom_range(0, 63) == 0);
            drive_cycle(1'($urandom), d, ($urandom_range(0, 3) != 0), rs);
        end
        m_ready = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
